// File: rtl/alu_pkg.sv
// Shared ALU definitions: slice width, add/sub sequencer states and flag bit positions.
package alu_pkg;

    localparam int SLICE_W    = 8;
    localparam int FLAG_COUNT = 4;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

endpackage

// File: rtl/adder_8bit.sv
// 8-bit ripple-carry adder with carry in and carry out.
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < 8; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[8];
    end

endmodule

// File: rtl/alu_addsub_seq.sv
// Multi-cycle add/subtract: one 8-bit slice per clock, LSB slice first, carry chained
// through a register, result and C/Z/N/V flags offered over a valid/ready handshake.
module alu_addsub_seq
    import alu_pkg::*;
#(
    parameter int NSLICES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SLICE_W*NSLICES-1:0] op_a,
    input  logic [SLICE_W*NSLICES-1:0] op_b,
    input  logic                       op_sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*NSLICES-1:0] result,
    output logic                       flag_c,
    output logic                       flag_z,
    output logic                       flag_n,
    output logic                       flag_v
);

    localparam int W     = SLICE_W * NSLICES;
    localparam int IDX_W = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

    addsub_state_t state, next_state;

    logic [IDX_W-1:0]      idx;
    logic [W-1:0]          a_q;
    logic [W-1:0]          b_q;
    logic [W-1:0]          result_q;
    logic [W-1:0]          next_result;
    logic                  carry_q;
    logic [FLAG_COUNT-1:0] flags_q;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               last_slice;

    adder_8bit u_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Full-width view with the current slice merged in, so flags see the final value.
    always_comb begin
        slice_a     = a_q[SLICE_W*idx +: SLICE_W];
        slice_b     = b_q[SLICE_W*idx +: SLICE_W];
        next_result = result_q;
        next_result[SLICE_W*idx +: SLICE_W] = slice_sum;
        last_slice  = (idx == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (in_valid)   next_state = CALC;
            CALC:    if (last_slice) next_state = DONE;
            DONE:    if (out_ready)  next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= op_a;
                        b_q     <= op_sub ? ~op_b : op_b;
                        carry_q <= op_sub;
                        idx     <= '0;
                    end
                end
                CALC: begin
                    result_q <= next_result;
                    carry_q  <= slice_cout;
                    idx      <= idx + 1'b1;
                    if (last_slice) begin
                        flags_q[FLAG_C] <= slice_cout;
                        flags_q[FLAG_Z] <= (next_result == '0);
                        flags_q[FLAG_N] <= next_result[W-1];
                        flags_q[FLAG_V] <= (a_q[W-1] == b_q[W-1]) && (next_result[W-1] != a_q[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_q;
    assign flag_c    = flags_q[FLAG_C];
    assign flag_z    = flags_q[FLAG_Z];
    assign flag_n    = flags_q[FLAG_N];
    assign flag_v    = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_addsub_seq.sv
// Self-checking bench for alu_addsub_seq (NSLICES = 2): directed table, corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_alu_addsub_seq;

    localparam int NS = 2;
    localparam int W  = 8 * NS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_c, flag_z, flag_n, flag_v;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] r;
        logic         c, z, n, v;
    } vec_t;

    vec_t vecs[8];

    alu_addsub_seq #(.NSLICES(NS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [W-1:0] r,
                           input logic c, input logic z, input logic n, input logic v);
        chk({name, " result"}, 32'(result), 32'(r));
        chk({name, " C"}, 32'(flag_c), 32'(c));
        chk({name, " Z"}, 32'(flag_z), 32'(z));
        chk({name, " N"}, 32'(flag_n), 32'(n));
        chk({name, " V"}, 32'(flag_v), 32'(v));
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        vec_t e;
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int sr;
        int ur;
        e.a = a; e.b = b; e.sub = sub;
        if (sub) begin
            ur  = ua - ub;
            e.c = (ua >= ub);
            sr  = sa - sb;
        end else begin
            ur  = ua + ub;
            e.c = (ur > 65535);
            sr  = sa + sb;
        end
        e.r = W'(ur & 32'hFFFF);
        e.z = (e.r == 0);
        e.n = e.r[W-1];
        e.v = (sr > 32767) || (sr < -32768);
        return e;
    endfunction

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_sub   = sub;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) break;
            cyc++;
            chk({name, " in_ready busy"}, 32'(in_ready), 32'd0);
        end
        chk({name, " latency"}, 32'(cyc), 32'(NS));
    endtask

    task automatic handshake_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_vec(input string name, input vec_t t);
        launch(t.a, t.b, t.sub);
        wait_done(name);
        chk_out(name, t.r, t.c, t.z, t.n, t.v);
        handshake_out();
    endtask

    initial begin
        vec_t e;
        //          a         b        sub   r        c     z     n     v
        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{16'h5555, 16'h0000, 1'b1, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: DONE held 5 cycles while new requests are offered.
        launch(16'h0003, 16'h0004, 1'b0);
        wait_done("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_out("bp hold", 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            in_valid = (i % 2 == 0);
            op_a = 16'h1000; op_b = 16'h0200; op_sub = 1'b0;
        end
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp idle out_valid", 32'(out_valid), 32'd0);
        chk("bp idle in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done("bp new");
        chk_out("bp new", 16'h1200, 1'b0, 1'b0, 1'b0, 1'b0);
        handshake_out();

        // Reset one cycle after acceptance.
        launch(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_out("midrst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("midrst out_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        e = model(16'h0102, 16'h0304, 1'b0);
        chk("after rst model", 32'(e.r), 32'h0406);
        run_vec("after rst", e);

        // Random operations with random output stalls.
        for (int k = 0; k < 40; k++) begin
            int stall;
            e = model(W'($urandom), W'($urandom), 1'($urandom));
            if (k % 8 == 0) e = model(16'h8000 ^ W'($urandom_range(0, 3)), W'($urandom_range(0, 3)), 1'($urandom));
            launch(e.a, e.b, e.sub);
            wait_done($sformatf("rnd%0d", k));
            stall = $urandom_range(0, 2);
            for (int s = 0; s < stall; s++) @(negedge clk);
            chk_out($sformatf("rnd%0d a=%h b=%h sub=%0d", k, e.a, e.b, e.sub), e.r, e.c, e.z, e.n, e.v);
            handshake_out();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_addsub_seq.md
# alu_addsub_seq

Multi-cycle add/subtract unit that widens the team's existing `adder_8bit` ripple adder to `8*NSLICES`-bit operands. It processes one 8-bit slice per clock, least significant slice first, and chains the carry through a register. It accepts operands over a valid/ready handshake, drives the single `adder_8bit` instance, and collects its sum and carry-out into a result register. It then presents the result with C/Z/N/V flags to the downstream register-file write port over a second valid/ready handshake.

## Interface
- `NSLICES`, default 2: number of 8-bit slices; operand width `W = 8*NSLICES`; legal range 1–16.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand request valid.
- `in_ready`  out  1  unit can accept a request.
- `op_a`  in  W  first operand.
- `op_b`  in  W  second operand.
- `op_sub`  in  1  0 = `a+b`, 1 = `a-b`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  W  sum or difference, modulo 2^W.
- `flag_c`  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- `flag_z`  out  1  result == 0.
- `flag_n`  out  1  `result[W-1]`.
- `flag_v`  out  1  signed overflow.

## Operation
- FSM states: IDLE, CALC, DONE.
- `in_ready = (state == IDLE)`.
- `out_valid = (state == DONE)`.
- IDLE: on `in_valid && in_ready`:
  - latch `a_q = op_a`;
  - latch `b_q = op_sub ? ~op_b : op_b`;
  - set `carry_q = op_sub` and `idx = 0`;
  - go to CALC.
- CALC: the `adder_8bit` inputs are slice `idx` of `a_q`/`b_q`, with `cin = carry_q`.
  - Each cycle: write the sum into `result[8*idx +: 8]`, set `carry_q <= cout`, increment `idx`.
  - On the cycle `idx == NSLICES-1`, the final slice is written and the flags are registered from the complete next-result:
    - `flag_c = cout`;
    - `flag_z = (next_result == 0)`;
    - `flag_n = next_result[W-1]`;
    - `flag_v = (a_q[W-1] == b_q[W-1]) && (next_result[W-1] != a_q[W-1])`.
  - The state then goes to DONE.
- DONE: `result` and the flags are held stable. On `out_valid && out_ready`, go to IDLE.
  - `out_valid` never deasserts without the handshake.
  - `in_valid` is ignored in DONE; there is no overlap between operations.
- Width rules:
  - the result wraps modulo 2^W;
  - subtraction is two's-complement (`~b + 1` via `cin`);
  - `idx` is `$clog2(NSLICES)` bits wide, minimum 1.
- The upper slices of `result` hold their previous values until overwritten. `result` is not valid outside DONE.

## Timing
- Reset (`rst` high at an edge):
  - state = IDLE, `idx = 0`, `carry_q = 0`;
  - `result = 0`, all flags 0;
  - `out_valid = 0`;
  - `in_ready = 1` from the first cycle after the reset edge.
- Reset mid-CALC or in DONE aborts the operation. No `out_valid` is produced and the pending result is discarded.
- Latency:
  - the accept edge is T;
  - slices are computed at edges T+1 … T+NSLICES;
  - `out_valid` is high from edge T+NSLICES.
  - For `NSLICES = 2`, `out_valid` is seen 2 cycles after acceptance.
- Throughput: one operation per `NSLICES+2` cycles when `out_ready` is held high. A new request can be accepted the cycle after the output handshake.
- Simultaneous events: `rst` wins over every handshake. In DONE, `out_ready` together with `in_valid` completes the output only; the input is accepted the next cycle.

## Structure
- Shared package `alu_pkg`:
  - `SLICE_W = 8`;
  - state enum `addsub_state_t {IDLE, CALC, DONE}`;
  - flag index constants `FLAG_C/Z/N/V`, for reuse by the flags register.
- Sub-module: exactly one existing `adder_8bit` instance.
- No new arithmetic sub-module; the slice mux, FSM and flag logic live in `alu_addsub_seq`.

## Test plan
All scenarios use `NSLICES = 2`.
- Add `0x00FF + 0x0001`:
  - required: `result = 0x0100`, C=0 Z=0 N=0 V=0;
  - `out_valid` 2 cycles after accept;
  - `in_ready` low throughout.
- Subtract `0x0000 - 0x0001`:
  - required: `result = 0xFFFF`, C=0 (borrow), N=1, Z=0, V=0.
- Overflow/wrap:
  - `0x7FFF + 0x0001` → `0x8000`, V=1, N=1, C=0;
  - `0xFFFF + 0x0001` → `0x0000`, C=1, Z=1, V=0.
- Equal subtract `0x1234 - 0x1234` → `0x0000`, Z=1, C=1, V=0.
- Backpressure:
  - stimulus: hold `out_ready = 0` for 5 cycles in DONE while toggling `in_valid` with new operands;
  - required: `result` and flags are unchanged, `in_ready = 0`, and the new operands are not accepted;
  - required: after `out_ready` is raised, IDLE follows, then the new request is accepted and computed correctly.
- Reset mid-CALC:
  - stimulus: assert `rst` one cycle after accepting `0x1111 + 0x2222`;
  - required: `out_valid` never rises, and all outputs are 0 after the reset edge;
  - required: a following `0x0102 + 0x0304` yields `0x0406`.
